// File: rtl/event_win_pkg.sv
// Shared types and helpers for the event-window buffer: window sizing,
// FSM state encoding and {row,col} address split functions.
package event_win_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    SHIFT,
    FLUSH
  } state_t;

  function automatic int win_of(input int half_win);
    return 2 * half_win + 1;
  endfunction

  function automatic logic [31:0] addr_row(input logic [63:0] addr, input int col_bits);
    return 32'(addr >> col_bits);
  endfunction

  function automatic logic [31:0] addr_col(input logic [63:0] addr, input int col_bits);
    return 32'(addr & ((64'd1 << col_bits) - 64'd1));
  endfunction

endpackage

// File: rtl/event_window_buf_if.sv
// Event-in / window-read bus of the event-window buffer. The master drives
// events, reads and clear; the slave (the buffer) returns status and data.
interface event_window_buf_if
  import event_win_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ROW_BITS   = 8,
  parameter int COL_BITS   = 8,
  parameter int HALF_WIN   = 1
);
  localparam int WIN    = win_of(HALF_WIN);
  localparam int ADDR_W = ROW_BITS + COL_BITS;

  logic                           clr;
  logic                           in_valid;
  logic                           in_ready;
  logic [ADDR_W-1:0]              in_addr;
  logic [DATA_WIDTH-1:0]          in_value;
  logic                           write_done;
  logic                           rd_req;
  logic [ADDR_W-1:0]              rd_addr;
  logic                           out_valid;
  logic [WIN*WIN*DATA_WIDTH-1:0]  out_window;
  logic [ROW_BITS-1:0]            base_row;
  logic [15:0]                    drop_cnt;

  modport master (
    output clr, in_valid, in_addr, in_value, rd_req, rd_addr,
    input  in_ready, write_done, out_valid, out_window, base_row, drop_cnt
  );

  modport slave (
    input  clr, in_valid, in_addr, in_value, rd_req, rd_addr,
    output in_ready, write_done, out_valid, out_window, base_row, drop_cnt
  );

endinterface

// File: rtl/event_win_row_mem.sv
// WIN row slots x COLS cells with write/shift/flush/clear and one registered
// WIN x WIN window read port. EVENT_WIN_ACCUM_EN selects saturating-add writes.
module event_win_row_mem
  import event_win_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ROW_BITS   = 8,
  parameter int COL_BITS   = 8,
  parameter int HALF_WIN   = 1,
  localparam int WIN       = win_of(HALF_WIN),
  localparam int SLOT_BITS = (WIN > 1) ? $clog2(WIN) : 1,
  localparam int COLS      = 2 ** COL_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [SLOT_BITS-1:0]          wr_slot,
  input  logic [COL_BITS-1:0]           wr_col,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          shift_en,
  input  logic                          flush_en,
  input  logic                          rd_en,
  input  logic [ROW_BITS-1:0]           rd_row,
  input  logic [COL_BITS-1:0]           rd_col,
  input  logic [ROW_BITS-1:0]           base_row,
  output logic                          rd_valid,
  output logic [WIN*WIN*DATA_WIDTH-1:0] rd_window
);

  logic [DATA_WIDTH-1:0] mem [WIN][COLS];
  logic [DATA_WIDTH-1:0] wr_value;
  logic [WIN*WIN*DATA_WIDTH-1:0] nxt_window;

`ifdef EVENT_WIN_ACCUM_EN
  logic [DATA_WIDTH:0] sum;

  always_comb begin
    sum      = {1'b0, mem[wr_slot][wr_col]} + {1'b0, wr_data};
    wr_value = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
  end
`else
  assign wr_value = wr_data;
`endif

  // NOTE: the store is reset explicitly because a post-reset window read must
  // return zeros; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < WIN; s++)
        for (int c = 0; c < COLS; c++)
          mem[s][c] <= '0;
    end else if (clr || flush_en) begin
      for (int s = 0; s < WIN; s++)
        for (int c = 0; c < COLS; c++)
          mem[s][c] <= '0;
    end else if (shift_en) begin
      for (int s = 0; s < WIN - 1; s++)
        for (int c = 0; c < COLS; c++)
          mem[s][c] <= mem[s+1][c];
      for (int c = 0; c < COLS; c++)
        mem[WIN-1][c] <= '0;
    end else if (wr_en) begin
      mem[wr_slot][wr_col] <= wr_value;
    end
  end

  // Signed integer arithmetic so cells above/below the resident rows and
  // beyond either column edge fall out as zero instead of wrapping.
  always_comb begin
    int slot;
    int col;
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    nxt_window = '0;
    slot       = 0;
    col        = 0;
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        slot = int'(rd_row) - HALF_WIN + i - int'(base_row);
        col  = int'(rd_col) - HALF_WIN + j;
        if (slot >= 0 && slot < WIN && col >= 0 && col < COLS)
          nxt_window[(WIN*WIN-1-(i*WIN+j))*DATA_WIDTH +: DATA_WIDTH] =
            mem[slot[SLOT_BITS-1:0]][col[COL_BITS-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_window <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_window <= clr ? '0 : nxt_window;
    end
  end

endmodule

// File: rtl/event_window_buf.sv
// Sliding-row event store: FSM, row-distance evaluation and drop counting
// around event_win_row_mem. Build option: EVENT_WIN_ACCUM_EN (accumulating writes).
module event_window_buf
  import event_win_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ROW_BITS   = 8,
  parameter int COL_BITS   = 8,
  parameter int HALF_WIN   = 1
) (
  input logic               clk,
  input logic               rst_n,
  event_window_buf_if.slave bus
);

  localparam int WIN       = win_of(HALF_WIN);
  localparam int SLOT_BITS = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic signed [ROW_BITS:0] WIN_S  = (ROW_BITS + 1)'(WIN);
  localparam logic signed [ROW_BITS:0] WIN2_S = (ROW_BITS + 1)'(2 * WIN);

  state_t                  state;
  logic [ROW_BITS-1:0]     ev_row;
  logic [COL_BITS-1:0]     ev_col;
  logic [DATA_WIDTH-1:0]   ev_value;
  logic [ROW_BITS-1:0]     base_row_q;
  logic [15:0]             drop_cnt_q;
  logic                    in_ready_q;
  logic                    write_done_q;

  logic signed [ROW_BITS:0] diff;
  logic                     in_window;
  logic [ROW_BITS-1:0]      rd_row;
  logic [COL_BITS-1:0]      rd_col;

  // Widened by one bit so a row behind base_row is negative, never wrapped.
  assign diff      = $signed({1'b0, ev_row}) - $signed({1'b0, base_row_q});
  assign in_window = (diff >= 0) && (diff < WIN_S);

  assign rd_row = ROW_BITS'(addr_row(64'(bus.rd_addr), COL_BITS));
  assign rd_col = COL_BITS'(addr_col(64'(bus.rd_addr), COL_BITS));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ev_row       <= '0;
      ev_col       <= '0;
      ev_value     <= '0;
      base_row_q   <= '0;
      drop_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      write_done_q <= 1'b0;
      if (bus.clr) begin
        state      <= IDLE;
        base_row_q <= '0;
        drop_cnt_q <= '0;
        in_ready_q <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.in_valid && in_ready_q) begin
              ev_row     <= ROW_BITS'(addr_row(64'(bus.in_addr), COL_BITS));
              ev_col     <= COL_BITS'(addr_col(64'(bus.in_addr), COL_BITS));
              ev_value   <= bus.in_value;
              in_ready_q <= 1'b0;
              state      <= EVAL;
            end else begin
              in_ready_q <= 1'b1;
            end
          end
          EVAL: begin
            if (diff < 0) begin
              if (drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
              in_ready_q <= 1'b1;
              state      <= IDLE;
            end else if (diff < WIN_S) begin
              write_done_q <= 1'b1;
              in_ready_q   <= 1'b1;
              state        <= IDLE;
            end else if (diff < WIN2_S) begin
              state <= SHIFT;
            end else begin
              state <= FLUSH;
            end
          end
          SHIFT: begin
            base_row_q <= base_row_q + 1'b1;
            state      <= EVAL;
          end
          FLUSH: begin
            // Land the event in the top slot on the following EVAL.
            base_row_q <= ev_row - ROW_BITS'(WIN - 1);
            state      <= EVAL;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  event_win_row_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ROW_BITS   (ROW_BITS),
    .COL_BITS   (COL_BITS),
    .HALF_WIN   (HALF_WIN)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.clr),
    .wr_en     ((state == EVAL) && in_window),
    .wr_slot   (diff[SLOT_BITS-1:0]),
    .wr_col    (ev_col),
    .wr_data   (ev_value),
    .shift_en  (state == SHIFT),
    .flush_en  (state == FLUSH),
    .rd_en     (bus.rd_req),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .base_row  (base_row_q),
    .rd_valid  (bus.out_valid),
    .rd_window (bus.out_window)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.write_done = write_done_q;
  assign bus.base_row   = base_row_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_event_window_buf.sv
// Directed self-checking bench for event_window_buf with hand-computed windows;
// expectations follow EVENT_WIN_ACCUM_EN when the build defines it.
module tb_event_window_buf;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  event_window_buf_if bus ();

  event_window_buf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int row, input int col, input int val);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", 64'(bus.in_ready), 64'(1));
    bus.in_addr  = {row[7:0], col[7:0]};
    bus.in_value = 4'(val);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Cycles from the accept edge (counted as 1) to the edge raising write_done.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.write_done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic read_win(input int row, input int col, output logic [35:0] w);
    bus.rd_addr = {row[7:0], col[7:0]};
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
    check("rd_out_valid", 64'(bus.out_valid), 64'(1));
    w = bus.out_window;
  endtask

  initial begin
    logic [35:0] w;
    int          lat;
    int          n;
    logic        seen;

    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_value = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   64'(bus.in_ready),   64'(0));
    check("rst_write_done", 64'(bus.write_done), 64'(0));
    check("rst_out_valid",  64'(bus.out_valid),  64'(0));
    check("rst_out_window", 64'(bus.out_window), 64'(0));
    check("rst_base_row",   64'(bus.base_row),   64'(0));
    check("rst_drop_cnt",   64'(bus.drop_cnt),   64'(0));
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(bus.in_ready), 64'(1));

    // Single event and centred read.
    send(2, 5, 7);
    check("eval_no_done", 64'(bus.write_done), 64'(0));
    wait_done(lat);
    check("lat_noshift", 64'(lat), 64'(2));
    tick();
    check("done_pulse_end", 64'(bus.write_done), 64'(0));
    read_win(1, 5, w);
    check("win_single", 64'(w), 64'h0_0000_0070);
    tick();
    check("out_valid_pulse", 64'(bus.out_valid), 64'(0));
    check("win_hold", 64'(bus.out_window), 64'h0_0000_0070);

    // Rows 0..2 resident, then row 4 forces two shifts.
    send(0, 3, 3); wait_done(lat);
    send(1, 3, 4); wait_done(lat);
    send(2, 3, 5); wait_done(lat);
    send(4, 3, 9);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      n++;
      tick();
    end
    check("shift_busy_cycles", 64'(n), 64'(5));
    check("shift_write_done", 64'(bus.write_done), 64'(1));
    check("shift_base_row", 64'(bus.base_row), 64'(2));
    read_win(1, 3, w);
    check("win_row0_gone", 64'(w), 64'h0_0000_0050);
    read_win(3, 4, w);
    check("win_after_shift", 64'(w), 64'h5_0700_0900);

    // Clear with a coincident read returns zeros.
    bus.clr     = 1'b1;
    bus.rd_addr = {8'd3, 8'd4};
    bus.rd_req  = 1'b1;
    tick();
    bus.clr    = 1'b0;
    bus.rd_req = 1'b0;
    check("clr_rd_valid",  64'(bus.out_valid),  64'(1));
    check("clr_rd_window", 64'(bus.out_window), 64'(0));
    check("clr_base_row",  64'(bus.base_row),   64'(0));

    // Far jump flushes, then a late event is dropped.
    send(200, 7, 6);
    wait_done(lat);
    check("lat_flush", 64'(lat), 64'(4));
    check("flush_base_row", 64'(bus.base_row), 64'(198));
    read_win(200, 7, w);
    check("win_flush", 64'(w), 64'h0_0006_0000);
    send(10, 1, 1);
    tick();
    check("drop_no_done", 64'(bus.write_done), 64'(0));
    check("drop_cnt", 64'(bus.drop_cnt), 64'(1));
    check("drop_ready", 64'(bus.in_ready), 64'(1));

    // Column edges do not wrap.
    send(199, 0, 3);   wait_done(lat);
    send(199, 255, 4); wait_done(lat);
    read_win(199, 0, w);
    check("win_col_lo", 64'(w), 64'h0_0003_0000);
    read_win(199, 255, w);
    check("win_col_hi", 64'(w), 64'h0_0004_0000);

    // Same-edge write and read returns the old value.
    send(200, 0, 5);
    bus.rd_addr = {8'd199, 8'd1};
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("collide_done", 64'(bus.write_done), 64'(1));
    check("collide_old", 64'(bus.out_window), 64'h0_0030_0000);
    read_win(199, 1, w);
    check("collide_new", 64'(w), 64'h0_0030_0500);

    // Second write to one cell: saturating add or overwrite.
    send(200, 2, 12); wait_done(lat);
    send(200, 2, 9);  wait_done(lat);
    read_win(200, 2, w);
`ifdef EVENT_WIN_ACCUM_EN
    check("accum_sat", 64'(w), 64'h0_000F_0000);
`else
    check("overwrite", 64'(w), 64'h0_0009_0000);
`endif

    // Clear while shifting: no write_done, state and memory zeroed.
    send(203, 1, 2);
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_shift_done", 64'(bus.write_done), 64'(0));
    check("clr_shift_base", 64'(bus.base_row), 64'(0));
    check("clr_shift_ready", 64'(bus.in_ready), 64'(1));
    check("clr_drop_cnt", 64'(bus.drop_cnt), 64'(0));
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.write_done) seen = 1'b1;
    end
    check("clr_no_late_done", 64'(seen), 64'(0));
    read_win(1, 1, w);
    check("clr_mem_zero", 64'(w), 64'(0));

    // Reset while shifting: event discarded, memory zeroed.
    send(0, 0, 8); wait_done(lat);
    send(4, 1, 2);
    tick();
    rst_n = 1'b0;
    #2;
    check("rst_mid_ready", 64'(bus.in_ready), 64'(0));
    check("rst_mid_done", 64'(bus.write_done), 64'(0));
    check("rst_mid_base", 64'(bus.base_row), 64'(0));
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.write_done) seen = 1'b1;
    end
    check("rst_no_late_done", 64'(seen), 64'(0));
    check("rst_mid_ready_after", 64'(bus.in_ready), 64'(1));
    read_win(1, 1, w);
    check("rst_mem_zero", 64'(w), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
